// File: rtl/busarb_rr.sv
// Round-robin bus arbiter for N_MASTERS requesters with active-low request/grant.
// The grant parks on the last owner, and a contended owner's tenure is capped at MAX_HOLD cycles.
module busarb_rr #(
  parameter  int unsigned N_MASTERS = 4,
  parameter  int unsigned MAX_HOLD  = 16,
  localparam int unsigned IDW       = ($clog2(N_MASTERS) > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] breq_,
  output logic [N_MASTERS-1:0] bgrt_,
  output logic [IDW-1:0]       gnt_id,
  output logic                 preempt
);

  localparam int unsigned HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_MAX  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX);

  logic [N_MASTERS-1:0] req;
  logic [HW-1:0]        hold_cnt;
  logic [HW-1:0]        nxt_hold;
  logic [IDW-1:0]       nxt_owner;
  logic                 nxt_preempt;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       cand;
  logic                 found;
  logic                 owner_req;

  assign req       = ~breq_;
  assign owner_req = req[gnt_id];

  // Search starts one past the owner, so the owner itself is never picked.
  always_comb begin
    pick  = gnt_id;
    cand  = gnt_id;
    found = 1'b0;
    for (int unsigned k = 1; k < N_MASTERS; k++) begin
      cand = IDW'((32'(gnt_id) + k) % N_MASTERS);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_owner   = gnt_id;
    nxt_hold    = hold_cnt;
    nxt_preempt = 1'b0;
    if (owner_req) begin
      if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && found) begin
        nxt_owner   = pick;
        nxt_hold    = '0;
        nxt_preempt = 1'b1;
      end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) begin
        nxt_hold = hold_cnt + HW'(1);
      end
    end else if (found) begin
      nxt_owner = pick;
      nxt_hold  = '0;
    end else begin
      nxt_hold = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_id   <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
      bgrt_    <= ~N_MASTERS'(1);
    end else begin
      gnt_id   <= nxt_owner;
      hold_cnt <= nxt_hold;
      preempt  <= nxt_preempt;
      bgrt_    <= ~(N_MASTERS'(1) << nxt_owner);
    end
  end

endmodule
